// File: rtl/pdm_feeder.sv
// pdm_feeder: sample FIFO, prime/run scheduler and clock-enable generator
// for the second-order PDM modulator. Samples arrive on a valid/ready stream.
// Playback starts once the FIFO is half full. A new sample is presented every
// OSR enables, and the enables are spaced CLK_DIV clocks apart.
// Optional feature macro: PDM_FEEDER_UNDERRUN_ZERO_EN. When it is defined, an
// underrun plays silence. When it is not defined, the previous sample is held.
module pdm_feeder #(
    parameter int INPUT_WIDTH = 8,
    parameter int CLK_DIV     = 16,
    parameter int OSR         = 64,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_en,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic signed [INPUT_WIDTH-1:0]         s_data,
    output logic                                  o_ce,
    output logic signed [INPUT_WIDTH-1:0]         o_func,
    output logic                                  o_busy,
    output logic                                  o_underrun,
    input  logic                                  i_clr_underrun,
    output logic [$clog2(FIFO_DEPTH):0]           o_level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int OSR_W = (OSR > 1) ? $clog2(OSR) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [INPUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    level;
    logic [DIV_W-1:0] div_cnt;
    logic [OSR_W-1:0] ce_cnt;

    logic fifo_full, fifo_empty, push;
    logic boundary, run_entry, pop_req, stop_now;
    logic pop_ok, underrun_evt;

    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign s_ready    = !fifo_full;
    assign push       = s_valid && s_ready;
    assign o_level    = level;
    assign o_busy     = (state == RUN);

    // The edge that closes the last enable of a sample period.
    assign boundary = (state == RUN) && o_ce && (ce_cnt == OSR_W'(OSR - 1));

    // A pop that finds the FIFO empty is an underrun. A push on the same edge
    // lands too late to be seen by that pop.
    assign pop_ok       = pop_req && !fifo_empty;
    assign underrun_evt = pop_req && fifo_empty;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic and pop/stop strobes
    always_comb begin
        state_nxt = state;
        run_entry = 1'b0;
        pop_req   = 1'b0;
        stop_now  = 1'b0;
        case (state)
            IDLE: begin
                if (i_en) state_nxt = PRIME;
            end
            PRIME: begin
                if (!i_en) begin
                    state_nxt = IDLE;
                end else if (level >= LW'(FIFO_DEPTH / 2)) begin
                    state_nxt = RUN;
                    run_entry = 1'b1;
                    pop_req   = 1'b1;
                end
            end
            RUN: begin
                if (boundary) begin
                    if (i_en) begin
                        pop_req = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        stop_now  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // FIFO storage; data only, flushed logically by the pointer reset
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    // Enable divider and per-sample enable counter, restarted on RUN entry
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
            ce_cnt  <= '0;
            o_ce    <= 1'b0;
        end else if (run_entry) begin
            div_cnt <= '0;
            ce_cnt  <= '0;
            o_ce    <= 1'b0;
        end else if (state == RUN) begin
            div_cnt <= (div_cnt == DIV_W'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
            o_ce    <= (div_cnt == DIV_W'(CLK_DIV - 1)) && !stop_now;
            if (o_ce)
                ce_cnt <= (ce_cnt == OSR_W'(OSR - 1)) ? '0 : ce_cnt + 1'b1;
        end else begin
            div_cnt <= '0;
            ce_cnt  <= '0;
            o_ce    <= 1'b0;
        end
    end

    // Current sample: loaded on each pop, zeroed whenever playback is not running
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_func <= '0;
        end else if (pop_req) begin
            if (!fifo_empty) begin
                o_func <= mem[rd_ptr];
            end else begin
`ifdef PDM_FEEDER_UNDERRUN_ZERO_EN
                o_func <= '0;
`else
                o_func <= o_func;
`endif
            end
        end else if (state_nxt != RUN) begin
            o_func <= '0;
        end
    end

    // Sticky underrun flag; a new underrun beats a simultaneous clear
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)            o_underrun <= 1'b0;
        else if (underrun_evt)   o_underrun <= 1'b1;
        else if (i_clr_underrun) o_underrun <= 1'b0;
    end

endmodule

// File: tb/tb_pdm_feeder.sv
// Directed testbench for pdm_feeder with CLK_DIV=4, OSR=4, FIFO_DEPTH=8.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pdm_feeder;

    localparam int INPUT_WIDTH = 8;
    localparam int CLK_DIV     = 4;
    localparam int OSR         = 4;
    localparam int FIFO_DEPTH  = 8;
    localparam int LW          = $clog2(FIFO_DEPTH) + 1;

`ifdef PDM_FEEDER_UNDERRUN_ZERO_EN
    localparam logic [7:0] UR_FUNC = 8'h00;
`else
    localparam logic [7:0] UR_FUNC = 8'h40;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          o_ce;
    logic [7:0]    o_func;
    logic          o_busy;
    logic          o_underrun;
    logic          clr;
    logic [LW-1:0] o_level;

    int tests = 0;
    int fails = 0;
    int cnt;

    always #5 clk = ~clk;

    pdm_feeder #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .CLK_DIV     (CLK_DIV),
        .OSR         (OSR),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_en           (en),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .o_ce           (o_ce),
        .o_func         (o_func),
        .o_busy         (o_busy),
        .o_underrun     (o_underrun),
        .i_clr_underrun (clr),
        .o_level        (o_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = 8'h00; clr = 1'b0;

        // 1. reset held for three cycles
        repeat (3) tick();
        check("rst_ce",       o_ce,       1'b0);
        check("rst_func",     o_func,     8'h00);
        check("rst_busy",     o_busy,     1'b0);
        check("rst_underrun", o_underrun, 1'b0);
        check("rst_level",    o_level,    0);
        check("rst_ready",    s_ready,    1'b1);
        rst_n = 1'b1;
        tick();

        // 2. prime with four samples, then enter RUN
        en = 1'b1; s_valid = 1'b1; s_data = 8'h10; tick();
        s_data = 8'h20; tick();
        s_data = 8'h30; tick();
        s_data = 8'h40; tick();
        s_valid = 1'b0;
        check("prime_level", o_level, 4);
        check("prime_busy",  o_busy,  1'b0);
        check("prime_ce",    o_ce,    1'b0);
        check("prime_func",  o_func,  8'h00);
        tick();
        check("entry_busy",  o_busy,  1'b1);
        check("entry_func",  o_func,  8'h10);
        check("entry_level", o_level, 3);
        check("entry_ce",    o_ce,    1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("ce_c%0d", k), o_ce, (k % 4 == 0) ? 1 : 0);
            check($sformatf("func_c%0d", k), o_func, 8'h10);
        end
        tick();
        check("b1_func",  o_func,  8'h20);
        check("b1_ce",    o_ce,    1'b0);
        check("b1_level", o_level, 2);

        // 3. drain to underrun, then clear the flag
        cnt = 0;
        repeat (16) begin tick(); cnt += int'(o_ce); end
        check("p2_pulses", cnt,     4);
        check("b2_func",   o_func,  8'h30);
        check("b2_level",  o_level, 1);
        repeat (16) tick();
        check("b3_func",     o_func,     8'h40);
        check("b3_level",    o_level,    0);
        check("b3_underrun", o_underrun, 1'b0);
        repeat (16) tick();
        check("ur_flag",  o_underrun, 1'b1);
        check("ur_func",  o_func,     UR_FUNC);
        check("ur_busy",  o_busy,     1'b1);
        check("ur_level", o_level,    0);
        s_valid = 1'b1; s_data = 8'h50; tick();
        s_valid = 1'b0;
        check("ur_sticky",     o_underrun, 1'b1);
        check("ur_push_level", o_level,    1);
        clr = 1'b1; tick();
        clr = 1'b0;
        check("ur_cleared", o_underrun, 1'b0);

        // 5. drop enable during the pulse with ce_cnt=1
        repeat (5) tick();
        check("stop_pulse_ce1", o_ce, 1'b1);
        en = 1'b0;
        cnt = 0;
        repeat (8) begin tick(); cnt += int'(o_ce); end
        check("stop_pulses",    cnt,    2);
        check("stop_busy_late", o_busy, 1'b1);
        tick();
        check("stop_busy",  o_busy,  1'b0);
        check("stop_func",  o_func,  8'h00);
        check("stop_ce",    o_ce,    1'b0);
        check("stop_level", o_level, 1);
        cnt = 0;
        repeat (8) begin tick(); cnt += int'(o_ce); end
        check("idle_pulses", cnt, 0);

        // flush before the fill test
        rst_n = 1'b0; tick();
        check("flush_level", o_level, 0);
        rst_n = 1'b1; tick();

        // 4. fill while idle with valid held
        s_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_data = 8'(i);
            tick();
        end
        check("full_level", o_level, 8);
        check("full_ready", s_ready, 1'b0);
        s_data = 8'h09; tick();
        check("full_hold_level", o_level, 8);
        check("full_idle_busy",  o_busy,  1'b0);
        en = 1'b1; tick();
        check("full_prime_busy", o_busy, 1'b0);
        tick();
        check("full_entry_busy",  o_busy,  1'b1);
        check("full_entry_func",  o_func,  8'h01);
        check("full_entry_level", o_level, 7);
        check("full_entry_ready", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
        check("ninth_level", o_level, 8);
        check("ninth_ready", s_ready, 1'b0);
        repeat (16) tick();
        check("order_func",  o_func,  8'h02);
        check("order_level", o_level, 7);
        s_valid = 1'b1; s_data = 8'h0A; tick();
        s_valid = 1'b0;
        check("refill_level", o_level, 8);

        // 6. reset mid-RUN while full
        rst_n = 1'b0; tick();
        check("mrst_level",    o_level,    0);
        check("mrst_ce",       o_ce,       1'b0);
        check("mrst_func",     o_func,     8'h00);
        check("mrst_busy",     o_busy,     1'b0);
        check("mrst_ready",    s_ready,    1'b1);
        check("mrst_underrun", o_underrun, 1'b0);
        rst_n = 1'b1; en = 1'b0;
        repeat (3) tick();
        check("mrst_idle_busy", o_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pdm_feeder.md
# pdm_feeder

Sample scheduler and clock-enable generator for the second-order PDM DAC modulator. It accepts signed PCM samples over a valid/ready stream into a small FIFO and primes the FIFO before starting playback. It then drives the modulator's clock-enable at a fixed divided rate and presents a new sample every OSR enables. It sits between the audio source (CPU/DMA, synth) and the modulator's `i_ce` / `i_func` inputs.

## Interface
- `INPUT_WIDTH`, 8: sample width. Two's complement; 0 = silence.
- `CLK_DIV`, 16: i_clk cycles per modulator enable. Must be ≥ 2.
- `OSR`, 64: modulator enables per sample. Must be ≥ 1.
- `FIFO_DEPTH`, 8: sample FIFO depth. Power of two, ≥ 2.
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset. Synchronous, active-low.
- `i_en`  in  1  playback enable.
- `s_valid`  in  1  sample valid.
- `s_ready`  out  1  FIFO can accept a sample.
- `s_data`  in  INPUT_WIDTH  sample.
- `o_ce`  out  1  modulator clock-enable. Connects to the modulator's `i_ce`.
- `o_func`  out  INPUT_WIDTH  current sample. Connects to the modulator's `i_func`.
- `o_busy`  out  1  state is RUN.
- `o_underrun`  out  1  sticky underrun flag.
- `i_clr_underrun`  in  1  clears `o_underrun`.
- `o_level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- **Reset values:** state IDLE; counters 0; FIFO empty; `o_ce`=0, `o_func`=0, `o_busy`=0, `o_underrun`=0, `o_level`=0, `s_ready`=1.
- **Push:** `s_valid && s_ready`. Accepted in every state. `s_ready` = !full. No push is possible while full.
- **FSM:**
  - **IDLE:** `o_ce`=0, `o_func`=0. Goes to PRIME when `i_en`=1.
  - **PRIME:** `o_ce`=0, `o_func`=0. Goes to IDLE if `i_en`=0. Goes to RUN when `o_level` ≥ FIFO_DEPTH/2.
  - **RUN:** `o_busy`=1. Goes to IDLE at the next sample boundary if `i_en`=0.
- **RUN entry:** the transition edge pops the FIFO head into `o_func` and clears `div_cnt` and `ce_cnt`.
- **Enable generation:** `div_cnt` counts 0..CLK_DIV-1 and wraps. Registered `o_ce` is 1 for exactly one cycle per CLK_DIV cycles.
- **Enable counting:** `ce_cnt` counts `o_ce` pulses 0..OSR-1 and wraps.
- **Sample boundary:** the edge that ends the `o_ce` cycle with `ce_cnt`=OSR-1.
  - If `i_en`=1: pop the next sample into `o_func`.
  - If `i_en`=0: go to IDLE with no pop. `o_func`=0, `o_ce`=0. FIFO contents are retained.
- **Underrun:** FIFO empty at a pop. Sets `o_underrun`; `o_func` per Configuration; RUN continues.
- **Underrun clear:** `i_clr_underrun` clears the flag. If an underrun and a clear occur in the same cycle, set wins.
- **Simultaneous push and pop:** `o_level` is unchanged. A push into an empty FIFO on the pop edge is not visible to that pop, so it counts as underrun.
- **FIFO:** circular buffer; pointers wrap at FIFO_DEPTH.
- **Reset mid-operation:** returns to the reset values at the next edge. FIFO is flushed.

## Timing
- Push to `o_level` update: 1 cycle.
- First `o_ce`: CLK_DIV cycles after the RUN-entry edge. Subsequent pulses every CLK_DIV cycles.
- Sample period: CLK_DIV×OSR cycles.
- `o_func` changes on the cycle after the OSR-th `o_ce` of a period, so it is stable across all enables of its period.
- `i_en` deassert in RUN: enables continue until the sample boundary; `o_ce` is 0 from then on.
- `o_busy` falls on the same edge as the RUN→IDLE transition.

## Configuration
- `PDM_FEEDER_UNDERRUN_ZERO_EN` defined: on underrun, `o_func` is loaded with 0 (silence) for that sample period.
- Not defined: on underrun, `o_func` holds the previous sample.
- `o_underrun` behaves identically in both cases.

## Test plan
All scenarios use INPUT_WIDTH=8, CLK_DIV=4, OSR=4, FIFO_DEPTH=8.
1. Reset with `i_rst_n`=0 for 3 cycles -> all outputs at reset values, `s_ready`=1.
2. `i_en`=1, push 0x10, 0x20, 0x30, 0x40 back-to-back -> RUN entered on the edge after the 4th push is counted (level 4). `o_func`=0x10 and `o_level`=3 after entry. `o_ce` pulses at cycles 4, 8, 12, 16 after entry. `o_func`=0x20 at cycle 17.
3. Continue scenario 2 with no further pushes -> 0x30 and 0x40 play in turn. At the next boundary `o_underrun`=1 and `o_func` holds 0x40 (0x00 with macro). Pulse `i_clr_underrun` with the FIFO nonempty -> flag clears.
4. `i_en`=0, push 9 samples with `s_valid` held -> 8 accepted, `s_ready`=0, `o_level`=8, state remains IDLE. The 9th is accepted the cycle after a pop frees a slot.
5. In RUN, drop `i_en` at `ce_cnt`=1 -> 2 more `o_ce` pulses, then IDLE, `o_func`=0, `o_busy`=0, `o_level` unchanged.
6. Assert reset mid-RUN while full -> next edge: `o_level`=0, `o_ce`=0, `o_func`=0, state IDLE.
